// File: rtl/input_debouncer.sv
// Turns a raw, possibly bouncing, asynchronous level into a clean clock-synchronous level.
// A synchronizer chain feeds a two-state FSM that needs DEBOUNCE_CYCLES identical samples before x follows.
module input_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   CNT_W           = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  output logic x,
  output logic busy
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   x_sync;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   x_q, x_d;
  logic                   busy_q, busy_d;

  // Only the last synchronizer stage is allowed to reach the FSM.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], x_raw};
  assign x_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (x_sync != x_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            x_d = x_sync;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_WAIT: begin
        if (x_sync == x_q) begin
          // Bounced back before qualifying: drop the candidate.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          x_d     = x_sync;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      x_q     <= RESET_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
    end
  end

  assign x    = x_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: a per-cycle vector table for the default debouncer, plus hand sequences
// for a fast variant (SYNC_STAGES=3, DEBOUNCE_CYCLES=1) followed by a rising-edge detector.
module tb_input_debouncer;

  typedef struct packed {
    logic rst;
    logic x_raw;
    logic exp_x;
    logic exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst, x_raw, x, busy;
  logic rst_f, x_raw_f, x_f, busy_f;
  logic x_f_prev = 1'b0;
  int   pulse_cnt = 0;
  logic busy_f_seen = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  input_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16), .RESET_LEVEL(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .x_raw(x_raw), .x(x), .busy(busy)
  );

  input_debouncer #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(16), .RESET_LEVEL(1'b0)
  ) u_fast (
    .clk(clk), .rst(rst_f), .x_raw(x_raw_f), .x(x_f), .busy(busy_f)
  );

  // Stand-in for the downstream pulse generator: one pulse per rising edge of x_f.
  always @(negedge clk) begin
    if (x_f === 1'b1 && x_f_prev === 1'b0) pulse_cnt <= pulse_cnt + 1;
    if (busy_f !== 1'b0) busy_f_seen <= 1'b1;
    x_f_prev <= x_f;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic xr, input logic ex, input logic eb);
    vecs.push_back({r, xr, ex, eb});
  endtask

  task automatic step_fast(input logic r, input logic xr);
    rst_f   = r;
    x_raw_f = xr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; x_raw = 1'b1; rst_f = 1'b1; x_raw_f = 1'b0;

    // reset with x_raw=1, then release: x rises 5 edges after first capture
    add(1,1,0,0); add(1,1,0,0);
    add(0,1,0,0); add(0,1,0,0); add(0,1,0,1); add(0,1,0,1); add(0,1,0,1); add(0,1,1,0);
    // clean falling edge
    add(0,0,1,0); add(0,0,1,0); add(0,0,1,1); add(0,0,1,1); add(0,0,1,1); add(0,0,0,0);
    add(0,0,0,0);
    // 3-cycle glitch: busy pulses, x never moves
    add(0,1,0,0); add(0,1,0,0); add(0,1,0,1); add(0,0,0,1); add(0,0,0,1); add(0,0,0,0);
    add(0,0,0,0);
    // bounce 1,0,1,0 then hold 1
    add(0,1,0,0); add(0,0,0,0); add(0,1,0,1); add(0,0,0,0); add(0,1,0,1); add(0,1,0,0);
    add(0,1,0,1); add(0,1,0,1); add(0,1,0,1); add(0,1,1,0); add(0,1,1,0);
    // reset while qualifying, then full restart
    add(1,0,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,1); add(0,1,0,1);
    add(1,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,1); add(0,1,0,1); add(0,1,0,1);
    add(0,1,1,0); add(0,1,1,0);

    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      x_raw = vecs[i].x_raw;
      @(posedge clk);
      #1;
      check($sformatf("x[v%0d]", i), x, vecs[i].exp_x);
      check($sformatf("busy[v%0d]", i), busy, vecs[i].exp_busy);
    end

    // Fast variant: x follows 3 edges after capture, busy never asserts.
    step_fast(1, 1);
    step_fast(1, 1);
    check("fast_reset_x", x_f, 1'b0);
    step_fast(0, 1);
    check("fast_rise_e0", x_f, 1'b0);
    step_fast(0, 1);
    check("fast_rise_e1", x_f, 1'b0);
    step_fast(0, 1);
    check("fast_rise_e2", x_f, 1'b0);
    step_fast(0, 1);
    check("fast_rise_e3", x_f, 1'b1);
    for (int k = 0; k < 3; k++) step_fast(0, 1);
    step_fast(0, 0);
    step_fast(0, 0);
    step_fast(0, 0);
    check("fast_fall_e2", x_f, 1'b1);
    step_fast(0, 0);
    check("fast_fall_e3", x_f, 1'b0);
    for (int k = 0; k < 3; k++) step_fast(0, 0);
    for (int k = 0; k < 4; k++) step_fast(0, 1);
    check("fast_rise2_e3", x_f, 1'b1);
    for (int k = 0; k < 3; k++) step_fast(0, 1);
    check("fast_busy_never", busy_f_seen, 1'b0);
    n_cmp++;
    if (pulse_cnt != 2) begin
      n_bad++;
      $display("FAIL fast_pulse_count: got %0d, want 2", pulse_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
